forwarding_hazard_unit: RTL and testbench

Parametrised forwarding and load-use hazard unit for the 5-stage pipeline. It tracks destination tags of in-flight instructions internally and generates registered per-operand bypass-mux selects for the instruction entering EX. It also raises a load-use stall and counts stall cycles. It sits between the ID/EX pipeline register and the EX operand muxes, and supersedes the purely combinational forwarding select logic.

---
 rtl/forwarding_hazard_unit_if.sv | 30 +++
 rtl/forwarding_hazard_unit.sv | 111 +++++++++++
 tb/tb_forwarding_hazard_unit.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/forwarding_hazard_unit_if.sv
// ID-stage to hazard-unit bundle: instruction tags in, bypass selects and stall out.
// SELW is derived here so producer and consumer always agree on the select width.
interface forwarding_hazard_unit_if #(
  parameter int unsigned AW      = 5,
  parameter int unsigned DEPTH   = 2,
  parameter int unsigned NUM_SRC = 2,
  parameter int unsigned CNT_W   = 16
);
  localparam int unsigned SELW = $clog2(DEPTH + 1);

  logic                      id_valid;
  logic [NUM_SRC*AW-1:0]     id_rs;
  logic [AW-1:0]             id_rd;
  logic                      id_we;
  logic                      id_load;
  logic                      flush;
  logic                      stall;
  logic [NUM_SRC*SELW-1:0]   fwd_sel;
  logic [CNT_W-1:0]          stall_cnt;

  modport master (
    output id_valid, id_rs, id_rd, id_we, id_load, flush,
    input  stall, fwd_sel, stall_cnt
  );

  modport slave (
    input  id_valid, id_rs, id_rd, id_we, id_load, flush,
    output stall, fwd_sel, stall_cnt
  );
endinterface

// File: rtl/forwarding_hazard_unit.sv
// Forwarding/load-use hazard unit: tracks in-flight destination tags and registers
// per-operand bypass selects for the instruction entering EX.
module forwarding_hazard_unit #(
  parameter int unsigned AW       = 5,
  parameter int unsigned DEPTH    = 2,
  parameter int unsigned NUM_SRC  = 2,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  forwarding_hazard_unit_if.slave  bus
);
  localparam int unsigned SELW = $clog2(DEPTH + 1);
  localparam int unsigned SW   = NUM_SRC * SELW;

  logic [DEPTH-1:0]               tag_valid;
  logic [DEPTH-1:0]               tag_we;
  logic [DEPTH-1:0]               tag_load;
  logic [AW-1:0]                  tag_rd [DEPTH];

  logic [NUM_SRC-1:0][DEPTH-1:0]  match_c;
  logic [SW-1:0]                  sel_c;
  logic [SW-1:0]                  idle_sel_c;
  logic                           load_hit_c;
  logic                           hazard_c;
  logic                           stall_c;
  logic                           advance_c;

  logic [SW-1:0]                  fwd_sel_q;
  logic [CNT_W-1:0]               stall_cnt_q;

  // Producer match per operand/source; register 0 is hardwired and never bypassed
  always_comb begin
    match_c = '0;
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      for (int k = 0; k < int'(DEPTH); k++) begin
        match_c[i][k] = tag_valid[k] & tag_we[k]
                      & (tag_rd[k] == bus.id_rs[i*AW +: AW])
                      & ~((ZERO_REG != 0) & (tag_rd[k] == '0));
      end
    end
  end

  // Youngest matching producer wins: scan oldest first so younger overrides
  always_comb begin
    sel_c      = '0;
    idle_sel_c = '0;
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      idle_sel_c[i*SELW +: SELW] = SELW'(DEPTH);
      sel_c[i*SELW +: SELW]      = SELW'(DEPTH);
      for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
        if (match_c[i][k]) begin
          sel_c[i*SELW +: SELW] = SELW'(k);
        end
      end
    end
  end

  // Load in EX feeding any operand of the ID instruction cannot be bypassed yet
  always_comb begin
    load_hit_c = 1'b0;
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      load_hit_c = load_hit_c | match_c[i][0];
    end
    hazard_c  = bus.id_valid & tag_valid[0] & tag_load[0] & load_hit_c;
    stall_c   = hazard_c & ~bus.flush;
    advance_c = bus.id_valid & ~bus.flush & ~stall_c;
  end

  // Tag pipeline shifts every cycle; only entry 0 depends on whether ID advanced
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_valid   <= '0;
      tag_we      <= '0;
      tag_load    <= '0;
      for (int k = 0; k < int'(DEPTH); k++) begin
        tag_rd[k] <= '0;
      end
      fwd_sel_q   <= idle_sel_c;
      stall_cnt_q <= '0;
    end else begin
      for (int k = 1; k < int'(DEPTH); k++) begin
        tag_valid[k] <= tag_valid[k-1];
        tag_we[k]    <= tag_we[k-1];
        tag_load[k]  <= tag_load[k-1];
        tag_rd[k]    <= tag_rd[k-1];
      end
      if (advance_c) begin
        tag_valid[0] <= 1'b1;
        tag_we[0]    <= bus.id_we;
        tag_load[0]  <= bus.id_load;
        tag_rd[0]    <= bus.id_rd;
        fwd_sel_q    <= sel_c;
      end else begin
        tag_valid[0] <= 1'b0;
        tag_we[0]    <= 1'b0;
        tag_load[0]  <= 1'b0;
        tag_rd[0]    <= '0;
        fwd_sel_q    <= idle_sel_c;
      end
      if (stall_c && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
    end
  end

  assign bus.stall     = stall_c;
  assign bus.fwd_sel   = fwd_sel_q;
  assign bus.stall_cnt = stall_cnt_q;
endmodule

// File: tb/tb_forwarding_hazard_unit.sv
// Directed bench for forwarding_hazard_unit: DEPTH=2 unit with a 16-bit counter and
// a second instance with a 2-bit counter for saturation.
module tb_forwarding_hazard_unit;
  logic clk;
  logic rst;
  int   checks;
  int   passes;

  forwarding_hazard_unit_if #(.AW(5), .DEPTH(2), .NUM_SRC(2), .CNT_W(16)) a_if ();
  forwarding_hazard_unit_if #(.AW(5), .DEPTH(2), .NUM_SRC(2), .CNT_W(2))  b_if ();

  forwarding_hazard_unit #(
    .AW(5), .DEPTH(2), .NUM_SRC(2), .ZERO_REG(1), .CNT_W(16)
  ) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (a_if.slave)
  );

  forwarding_hazard_unit #(
    .AW(5), .DEPTH(2), .NUM_SRC(2), .ZERO_REG(1), .CNT_W(2)
  ) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (b_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic v, input logic [4:0] r0, input logic [4:0] r1,
                         input logic [4:0] rd, input logic we, input logic ld,
                         input logic fl);
    a_if.id_valid = v;
    a_if.id_rs    = {r1, r0};
    a_if.id_rd    = rd;
    a_if.id_we    = we;
    a_if.id_load  = ld;
    a_if.flush    = fl;
  endtask

  task automatic drive_b(input logic v, input logic [4:0] r0, input logic [4:0] r1,
                         input logic [4:0] rd, input logic we, input logic ld,
                         input logic fl);
    b_if.id_valid = v;
    b_if.id_rs    = {r1, r0};
    b_if.id_rd    = rd;
    b_if.id_we    = we;
    b_if.id_load  = ld;
    b_if.flush    = fl;
  endtask

  task automatic drain_a();
    drive_a(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    repeat (3) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_a(1'b1, 5'($urandom_range(31)), 5'($urandom_range(31)), 5'($urandom_range(31)),
            1'b1, 1'b1, 1'($urandom_range(1)));
    drive_b(1'b1, 5'($urandom_range(31)), 5'($urandom_range(31)), 5'($urandom_range(31)),
            1'b1, 1'b1, 1'b0);
    tick();
    tick();
    checks++;
    if (a_if.fwd_sel !== 4'b1010) $display("FAIL reset_fwd_sel: got %b want 1010", a_if.fwd_sel);
    else passes++;
    checks++;
    if (a_if.stall !== 1'b0) $display("FAIL reset_stall: got %b want 0", a_if.stall);
    else passes++;
    checks++;
    if (a_if.stall_cnt !== 16'd0) $display("FAIL reset_cnt_a: got %0d want 0", a_if.stall_cnt);
    else passes++;
    checks++;
    if (b_if.stall_cnt !== 2'd0) $display("FAIL reset_cnt_b: got %0d want 0", b_if.stall_cnt);
    else passes++;
    rst = 1'b0;
    drive_b(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    drain_a();
  endtask

  task automatic test_back_to_back();
    drive_a(1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0);
    tick();
    drive_a(1'b1, 5'd5, 5'd6, 5'd10, 1'b0, 1'b0, 1'b0);
    tick();
    checks++;
    if (a_if.fwd_sel !== 4'b1000) $display("FAIL b2b_op0: got %b want 1000", a_if.fwd_sel);
    else passes++;
    drain_a();
    drive_a(1'b1, 5'd0, 5'd0, 5'd6, 1'b1, 1'b0, 1'b0);
    tick();
    drive_a(1'b1, 5'd5, 5'd6, 5'd10, 1'b0, 1'b0, 1'b0);
    tick();
    checks++;
    if (a_if.fwd_sel !== 4'b0010) $display("FAIL b2b_op1: got %b want 0010", a_if.fwd_sel);
    else passes++;
    drain_a();
  endtask

  task automatic test_distance();
    drive_a(1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0);
    tick();
    drive_a(1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0);
    tick();
    drive_a(1'b1, 5'd5, 5'd0, 5'd11, 1'b0, 1'b0, 1'b0);
    tick();
    checks++;
    if (a_if.fwd_sel !== 4'b1000) $display("FAIL youngest_wins: got %b want 1000", a_if.fwd_sel);
    else passes++;
    drain_a();
    drive_a(1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0);
    tick();
    drive_a(1'b1, 5'd0, 5'd0, 5'd9, 1'b1, 1'b0, 1'b0);
    tick();
    drive_a(1'b1, 5'd5, 5'd0, 5'd11, 1'b0, 1'b0, 1'b0);
    tick();
    checks++;
    if (a_if.fwd_sel !== 4'b1001) $display("FAIL distance2: got %b want 1001", a_if.fwd_sel);
    else passes++;
    drain_a();
    drive_a(1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0);
    tick();
    drive_a(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    drive_a(1'b1, 5'd5, 5'd0, 5'd11, 1'b0, 1'b0, 1'b0);
    tick();
    checks++;
    if (a_if.fwd_sel !== 4'b1010) $display("FAIL beyond_depth: got %b want 1010", a_if.fwd_sel);
    else passes++;
    drain_a();
  endtask

  task automatic test_load_use();
    drive_a(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 1'b1, 1'b0);
    tick();
    drive_a(1'b1, 5'd7, 5'd0, 5'd8, 1'b1, 1'b0, 1'b0);
    #1;
    checks++;
    if (a_if.stall !== 1'b1) $display("FAIL load_use_stall: got %b want 1", a_if.stall);
    else passes++;
    tick();
    checks++;
    if (a_if.stall !== 1'b0) $display("FAIL load_use_one_cycle: got %b want 0", a_if.stall);
    else passes++;
    checks++;
    if (a_if.stall_cnt !== 16'd1) $display("FAIL load_use_cnt: got %0d want 1", a_if.stall_cnt);
    else passes++;
    checks++;
    if (a_if.fwd_sel !== 4'b1010) $display("FAIL load_use_bubble: got %b want 1010", a_if.fwd_sel);
    else passes++;
    tick();
    checks++;
    if (a_if.fwd_sel !== 4'b1001) $display("FAIL load_use_sel: got %b want 1001", a_if.fwd_sel);
    else passes++;
    drain_a();
  endtask

  task automatic test_zero_nowrite();
    drive_a(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
    tick();
    drive_a(1'b1, 5'd0, 5'd0, 5'd12, 1'b0, 1'b0, 1'b0);
    tick();
    checks++;
    if (a_if.fwd_sel !== 4'b1010) $display("FAIL zero_reg: got %b want 1010", a_if.fwd_sel);
    else passes++;
    drain_a();
    drive_a(1'b1, 5'd0, 5'd0, 5'd4, 1'b0, 1'b0, 1'b0);
    tick();
    drive_a(1'b1, 5'd4, 5'd0, 5'd12, 1'b0, 1'b0, 1'b0);
    tick();
    checks++;
    if (a_if.fwd_sel !== 4'b1010) $display("FAIL no_write: got %b want 1010", a_if.fwd_sel);
    else passes++;
    drain_a();
  endtask

  task automatic test_flush_hazard();
    drive_a(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 1'b1, 1'b0);
    tick();
    drive_a(1'b1, 5'd7, 5'd0, 5'd8, 1'b1, 1'b0, 1'b1);
    #1;
    checks++;
    if (a_if.stall !== 1'b0) $display("FAIL flush_stall: got %b want 0", a_if.stall);
    else passes++;
    tick();
    checks++;
    if (a_if.stall_cnt !== 16'd1) $display("FAIL flush_cnt: got %0d want 1", a_if.stall_cnt);
    else passes++;
    checks++;
    if (a_if.fwd_sel !== 4'b1010) $display("FAIL flush_sel: got %b want 1010", a_if.fwd_sel);
    else passes++;
    drive_a(1'b1, 5'd7, 5'd0, 5'd8, 1'b1, 1'b0, 1'b0);
    tick();
    checks++;
    if (a_if.fwd_sel !== 4'b1001) $display("FAIL flush_shift: got %b want 1001", a_if.fwd_sel);
    else passes++;
    drain_a();
  endtask

  task automatic test_saturation();
    for (int i = 1; i <= 5; i++) begin
      drive_b(1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 1'b1, 1'b0);
      tick();
      drive_b(1'b1, 5'd3, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      #1;
      checks++;
      if (b_if.stall !== 1'b1) $display("FAIL sat_stall_%0d: got %b want 1", i, b_if.stall);
      else passes++;
      tick();
      checks++;
      if (b_if.stall_cnt !== 2'((i > 3) ? 3 : i))
        $display("FAIL sat_cnt_%0d: got %0d want %0d", i, b_if.stall_cnt, (i > 3) ? 3 : i);
      else passes++;
      tick();
    end
    drive_b(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_stall();
    drive_a(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 1'b1, 1'b0);
    tick();
    drive_a(1'b1, 5'd7, 5'd0, 5'd8, 1'b1, 1'b0, 1'b0);
    #1;
    checks++;
    if (a_if.stall !== 1'b1) $display("FAIL mid_stall_pre: got %b want 1", a_if.stall);
    else passes++;
    rst = 1'b1;
    tick();
    checks++;
    if (a_if.stall !== 1'b0) $display("FAIL mid_stall_rst: got %b want 0", a_if.stall);
    else passes++;
    checks++;
    if (a_if.stall_cnt !== 16'd0) $display("FAIL mid_stall_cnt: got %0d want 0", a_if.stall_cnt);
    else passes++;
    rst = 1'b0;
    drain_a();
  endtask

  initial begin
    checks = 0;
    passes = 0;
    rst    = 1'b0;
    drive_a(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    drive_b(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    test_reset();
    test_back_to_back();
    test_distance();
    test_load_use();
    test_zero_nowrite();
    test_flush_hazard();
    test_saturation();
    test_reset_mid_stall();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
